// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: walks two WIDTH-bit operands through a single
// fullAdder cell, LSB first, and presents a registered sum/carry-out with a done pulse.

module fullAdder (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic sum,
    output logic carry
);
    assign sum   = a ^ b ^ c;
    assign carry = (a & b) | (c & (a ^ b));
endmodule

module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int            CW       = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    if (WIDTH < 2) begin : g_width_check
        $error("serial_add_ctrl: WIDTH must be at least 2");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_res_sh;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
    logic             w_fa_sum;
    logic             w_fa_carry;
    logic             w_accept;
    logic             w_run;
    logic             w_last;
    logic [WIDTH-1:0] w_res_shifted;

    fullAdder u_fa (
        .a    (r_a_sh[0]),
        .b    (r_b_sh[0]),
        .c    (r_carry),
        .sum  (w_fa_sum),
        .carry(w_fa_carry)
    );

    // A request is honoured from IDLE and also from DONE, which gives back-to-back throughput.
    assign w_run         = (r_state == S_RUN);
    assign w_accept      = start && !w_run;
    assign w_last        = w_run && (r_cnt == LAST_BIT);
    assign w_res_shifted = {w_fa_sum, r_res_sh[WIDTH-1:1]};

    // NOTE: every variable driven here gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_RUN;
            S_RUN:   if (r_cnt == LAST_BIT) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = start ? S_RUN : S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // NOTE: the whole datapath is reset so an abandoned operation leaves nothing stale behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_sh   <= '0;
            r_b_sh   <= '0;
            r_res_sh <= '0;
            r_carry  <= 1'b0;
            r_cnt    <= '0;
            r_sum    <= '0;
            r_cout   <= 1'b0;
        end else if (w_accept) begin
            r_a_sh  <= a;
            r_b_sh  <= b;
            r_carry <= cin;
            r_cnt   <= '0;
        end else if (w_run) begin
            r_a_sh   <= {1'b0, r_a_sh[WIDTH-1:1]};
            r_b_sh   <= {1'b0, r_b_sh[WIDTH-1:1]};
            r_res_sh <= w_res_shifted;
            r_carry  <= w_fa_carry;
            r_cnt    <= r_cnt + CW'(1);
            if (w_last) begin
                r_sum  <= w_res_shifted;
                r_cout <= w_fa_carry;
            end
        end
    end

    assign busy = w_run;
    assign done = (r_state == S_DONE);
    assign sum  = r_sum;
    assign cout = r_cout;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl: accept-time reference model for WIDTH=8,
// directed cases, random traffic, and an exhaustive sweep of a WIDTH=4 instance.

module tb_serial_add_ctrl;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a, b;
    logic         cin;
    logic         busy, done, cout;
    logic [W-1:0] sum;

    logic       start4, cin4, busy4, done4, cout4;
    logic [3:0] a4, b4, sum4;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    always #5 clk = ~clk;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
        .busy(busy), .done(done), .sum(sum), .cout(cout)
    );

    serial_add_ctrl #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .cin(cin4),
        .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: tracks only the edge index of the last accepted request and its
    // arithmetic result; busy/done/sum follow from the distance to that edge.
    int         m_edge = 0;
    int         m_acc  = -1000;
    logic [8:0] m_pend = '0;
    logic [8:0] m_res  = '0;
    bit         m_busy = 1'b0;
    bit         m_done = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_edge <= 0;
            m_acc  <= -1000;
            m_res  <= '0;
            m_busy <= 1'b0;
            m_done <= 1'b0;
        end else begin : model_step
            int         acc;
            logic [8:0] res;
            logic [8:0] pend;
            acc  = m_acc;
            res  = m_res;
            pend = m_pend;
            if (m_edge == acc + W) res = pend;
            if (start && (m_edge - acc >= W + 1)) begin
                acc  = m_edge;
                pend = {1'b0, a} + {1'b0, b} + {8'd0, cin};
            end
            m_acc  <= acc;
            m_res  <= res;
            m_pend <= pend;
            m_busy <= (m_edge - acc >= 0) && (m_edge - acc < W);
            m_done <= (m_edge - acc == W);
            m_edge <= m_edge + 1;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("cmp_busy", 32'(busy), 32'(m_busy));
            check("cmp_done", 32'(done), 32'(m_done));
            check("cmp_sum",  32'(sum),  32'(m_res[7:0]));
            check("cmp_cout", 32'(cout), 32'(m_res[8]));
        end
    end

    task automatic start_op(input logic [7:0] ta, input logic [7:0] tb_v, input logic tc);
        @(negedge clk);
        a = ta; b = tb_v; cin = tc; start = 1'b1;
        @(negedge clk);
        start = 1'b0; a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
    endtask

    task automatic wait_done(output int busy_cycles, output bit got);
        busy_cycles = 0;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            if (done) got = 1'b1;
            else begin
                if (busy) busy_cycles++;
                @(negedge clk);
            end
        end
    endtask

    task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_v, input logic tc,
                          input logic [7:0] exp_sum, input logic exp_cout, input string tag);
        int bc;
        bit got;
        start_op(ta, tb_v, tc);
        wait_done(bc, got);
        check({tag, "_done_seen"}, 32'(got), 32'd1);
        check({tag, "_busy_cycles"}, 32'(bc), 32'd8);
        check({tag, "_sum"}, 32'(sum), 32'(exp_sum));
        check({tag, "_cout"}, 32'(cout), 32'(exp_cout));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  bc, n, n_done, gaps;
        bit  got;
        rst_n = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        start4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_sum",  32'(sum),  32'd0);
        check("rst_cout", 32'(cout), 32'd0);
        @(posedge clk); #3 rst_n = 1'b1;

        run_op(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, "t5a3c");
        check("model_pin_96", 32'(m_res), 32'h096);
        run_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, "tff01");
        check("model_pin_100", 32'(m_res), 32'h100);
        run_op(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, "tffff");
        run_op(8'h00, 8'h00, 1'b1, 8'h01, 1'b0, "t0001");

        // A start pulse in the middle of RUN must be dropped.
        start_op(8'h01, 8'h02, 1'b0);
        repeat (2) @(negedge clk);
        start = 1'b1; a = 8'h11; b = 8'h22;
        @(negedge clk);
        start = 1'b0;
        wait_done(bc, got);
        check("ign_done_seen", 32'(got), 32'd1);
        check("ign_sum", 32'(sum), 32'h03);
        n_done = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) n_done++;
        end
        check("ign_no_second_done", 32'(n_done), 32'd0);

        // Held start: a completion every W+1 cycles, busy drops only for the done cycle.
        @(negedge clk);
        a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
        n_done = 0; gaps = 0;
        for (int i = 0; i < 27; i++) begin
            @(negedge clk);
            if (done) begin
                n_done++;
                check("b2b_sum", 32'(sum), 32'h30);
            end
            if (!busy && !done) gaps++;
        end
        start = 1'b0;
        check("b2b_done_count", 32'(n_done), 32'd3);
        check("b2b_idle_gaps", 32'(gaps), 32'd0);
        repeat (3) @(negedge clk);

        // Reset in the middle of RUN, then a request held across reset release.
        run_op(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, "pre_rst");
        start_op(8'h01, 8'h02, 1'b0);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_sum",  32'(sum),  32'd0);
        check("midrst_cout", 32'(cout), 32'd0);
        @(negedge clk);
        start = 1'b1; a = 8'h07; b = 8'h09; cin = 1'b0;
        @(posedge clk); #3 rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        start = 1'b0;
        wait_done(bc, got);
        check("postrst_done_seen", 32'(got), 32'd1);
        check("postrst_busy_cycles", 32'(bc), 32'd8);
        check("postrst_sum", 32'(sum), 32'h10);
        check("postrst_cout", 32'(cout), 32'd0);

        // Random traffic: start toggles freely, the model decides what is accepted.
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            start = ($urandom_range(0, 2) == 0);
            a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
        end
        start = 1'b0;
        repeat (12) @(negedge clk);

        // Exhaustive sweep of the 4-bit instance.
        for (int k = 0; k < 512; k++) begin
            @(negedge clk);
            a4 = 4'(k & 15); b4 = 4'((k >> 4) & 15); cin4 = 1'(k >> 8); start4 = 1'b1;
            @(posedge clk);
            n = 1;
            got = 1'b0;
            @(negedge clk);
            start4 = 1'b0;
            for (int i = 0; i < 20 && !got; i++) begin
                if (done4) got = 1'b1;
                else begin
                    @(posedge clk);
                    n++;
                    @(negedge clk);
                end
            end
            check("w4_latency", 32'(n), 32'd5);
            check("w4_result", 32'({cout4, sum4}), 32'((k & 15) + ((k >> 4) & 15) + (k >> 8)));
        end

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
